// File: rtl/display_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_ctrl_pkg
// Description : Shared constants and types for the 8-digit seven-segment scan
//               controller: FSM state encoding, digit count, anode-off value
//               and the digit index type.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package display_scan_ctrl_pkg;

  // FSM state encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BLANK = 2'd1;
  localparam logic [1:0] ON    = 2'd2;

  localparam int N_DIGITS = 8;

  // Anodes are active-low, so all-ones means every digit is dark
  localparam logic [N_DIGITS-1:0] AN_ALL_OFF = 8'hFF;

  typedef logic [$clog2(N_DIGITS)-1:0] digit_idx_t;

  localparam digit_idx_t LAST_DIGIT = digit_idx_t'(N_DIGITS - 1);

endpackage
`default_nettype wire

// File: rtl/display_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_ctrl_if
// Description : Bundle of the scan controller's control inputs and display
//               outputs.
// Ports       : en, digit_mask (upstream -> controller)
//               sel, an, blank, frame_done (controller -> display/upstream)
//               master modport : upstream side
//               slave modport  : controller side
// Revision    : 1.0 - initial release
// ============================================================================
interface display_scan_ctrl_if;
  import display_scan_ctrl_pkg::*;

  logic                en;
  logic [N_DIGITS-1:0] digit_mask;
  digit_idx_t          sel;
  logic [N_DIGITS-1:0] an;
  logic                blank;
  logic                frame_done;

  modport master (
    output en, digit_mask,
    input  sel, an, blank, frame_done
  );

  modport slave (
    input  en, digit_mask,
    output sel, an, blank, frame_done
  );

endinterface
`default_nettype wire

// File: rtl/display_scan_ctrl_decoder.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_ctrl_decoder
// Description : Gate-level 3-to-8 one-hot decoder used to turn the digit
//               index into an anode position.
// Ports       : sel    in  3  binary digit index
//               onehot out 8  bit sel is high, all others low
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan_ctrl_decoder
  import display_scan_ctrl_pkg::*;
(
  input  wire [2:0]          sel,
  output wire [N_DIGITS-1:0] onehot
);

  wire [2:0] w_sel_n;

  not u_inv0 (w_sel_n[0], sel[0]);
  not u_inv1 (w_sel_n[1], sel[1]);
  not u_inv2 (w_sel_n[2], sel[2]);

  // Each output is a 3-input AND of true/complement select literals
  for (genvar i = 0; i < N_DIGITS; i++) begin : g_dec
    localparam logic [2:0] c_code = 3'(i);
    and u_and (onehot[i],
               c_code[2] ? sel[2] : w_sel_n[2],
               c_code[1] ? sel[1] : w_sel_n[1],
               c_code[0] ? sel[0] : w_sel_n[0]);
  end

endmodule
`default_nettype wire

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_ctrl
// Description : Time-multiplexing scan controller for an 8-digit seven-
//               segment display. Each digit slot is a BLANK gap of BLANK_CYC
//               cycles followed by an ON phase of DIV cycles. The digit mask
//               is sampled only at frame boundaries or when leaving IDLE.
// Ports       : clk  in   system clock
//               rst  in   asynchronous active-high reset
//               bus  slave modport: en, digit_mask in;
//                    sel, an (active-low), blank, frame_done out
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int DIV       = 1000,
  parameter int BLANK_CYC = 16,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  display_scan_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] c_on_last    = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] c_blank_last = CNT_W'(BLANK_CYC - 1);

  logic [1:0]          r_state;
  logic [CNT_W-1:0]    r_cnt;
  digit_idx_t          r_sel;
  logic [N_DIGITS-1:0] r_mask;
  logic [N_DIGITS-1:0] r_an;
  logic                r_blank;
  logic                r_frame_done;

  logic [1:0]          w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  digit_idx_t          w_sel_nxt;
  logic [N_DIGITS-1:0] w_mask_nxt;
  logic [N_DIGITS-1:0] w_onehot;
  logic [N_DIGITS-1:0] w_lit;
  logic                w_frame_done_nxt;

  // Next-state logic. Outputs are registered from these next values so
  // anode, blank and sel all change on the same edge as the state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sel_nxt   = r_sel;
    w_mask_nxt  = r_mask;
    if (!bus.en) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_sel_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = BLANK;
          w_cnt_nxt   = '0;
          w_sel_nxt   = '0;
          w_mask_nxt  = bus.digit_mask;
        end
        BLANK: begin
          if (r_cnt == c_blank_last) begin
            w_state_nxt = ON;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ON: begin
          if (r_cnt == c_on_last) begin
            w_state_nxt = BLANK;
            w_cnt_nxt   = '0;
            if (r_sel == LAST_DIGIT) begin
              w_sel_nxt  = '0;
              w_mask_nxt = bus.digit_mask;
            end else begin
              w_sel_nxt = r_sel + digit_idx_t'(1);
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_sel_nxt   = '0;
        end
      endcase
    end
  end

  display_scan_ctrl_decoder u_dec (
    .sel    (w_sel_nxt),
    .onehot (w_onehot)
  );

  // One-hot qualified by mask and ON guarantees at most one lit anode
  assign w_lit = w_onehot & w_mask_nxt & {N_DIGITS{w_state_nxt == ON}};

  // Pulse covers the final ON cycle of the last digit
  assign w_frame_done_nxt = (w_state_nxt == ON) && (w_sel_nxt == LAST_DIGIT) &&
                            (w_cnt_nxt == c_on_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_sel        <= '0;
      r_mask       <= '0;
      r_an         <= AN_ALL_OFF;
      r_blank      <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_sel        <= w_sel_nxt;
      r_mask       <= w_mask_nxt;
      r_an         <= ~w_lit;
      r_blank      <= ~|w_lit;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign bus.sel        = r_sel;
  assign bus.an         = r_an;
  assign bus.blank      = r_blank;
  assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire
